// File: rtl/vocoder_pkg.sv
// Shared constants and types for the vocoder envelope path.
package vocoder_pkg;

  localparam int unsigned SampleW         = 32;
  localparam int unsigned DefaultNFilters = 8;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/env_update.sv
// Single-channel envelope step: rectify, then move towards the rectified sample
// by a shifted fraction of the difference (attack when rising, release when falling).
module env_update
  import vocoder_pkg::*;
(
  input  logic signed [SampleW-1:0] x_i,
  input  logic signed [SampleW-1:0] env_i,
  input  logic        [4:0]         attack_shift_i,
  input  logic        [4:0]         release_shift_i,
  output logic signed [SampleW-1:0] env_o
);

  localparam logic signed [SampleW:0] MaxMag = {2'b00, {(SampleW - 1){1'b1}}};

  logic signed [SampleW:0] x_ext;
  logic signed [SampleW:0] mag;
  logic signed [SampleW:0] r;
  logic signed [SampleW:0] e;
  logic signed [SampleW:0] rise;
  logic signed [SampleW:0] fall;
  logic signed [SampleW:0] nxt;

  always_comb begin
    x_ext = {x_i[SampleW-1], x_i};
    mag   = (x_ext < 0) ? -x_ext : x_ext;
    // Only the most negative sample rectifies past full scale.
    r     = (mag > MaxMag) ? MaxMag : mag;
    e     = {env_i[SampleW-1], env_i};
    rise  = (r - e) >>> attack_shift_i;
    fall  = (e - r) >>> release_shift_i;
    nxt   = (r > e) ? (e + rise) : (e - fall);
    env_o = SampleW'(nxt);
  end

endmodule

// File: rtl/envelope_follower.sv
// Time-multiplexed per-band envelope follower: one shared update datapath walks
// the channels of a latched frame, then pulses valid_out.
module envelope_follower
  import vocoder_pkg::*;
#(
  parameter int unsigned N_FILTERS = DefaultNFilters
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      valid_in,
  input  logic        [4:0]         attack_shift,
  input  logic        [4:0]         release_shift,
  input  logic signed [SampleW-1:0] filtered_channels [N_FILTERS],
  output logic signed [SampleW-1:0] envelope_channels [N_FILTERS],
  output logic                      valid_out,
  output logic                      busy_out,
  output logic                      overrun_out
);

  localparam int unsigned     IdxW    = $clog2(N_FILTERS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_FILTERS - 1);

  state_e                    state_q, state_d;
  logic        [IdxW-1:0]    idx_q;
  logic        [4:0]         atk_q, rel_q;
  logic signed [SampleW-1:0] x_q   [N_FILTERS];
  logic signed [SampleW-1:0] env_q [N_FILTERS];
  logic signed [SampleW-1:0] env_new;
  logic                      valid_q, overrun_q;
  logic                      accept, running, last;

  assign running = (state_q == StRun);
  assign accept  = (state_q == StIdle) && valid_in;
  assign last    = running && (idx_q == LastIdx);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (valid_in) state_d = StRun;
      StRun:   if (idx_q == LastIdx) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_out = running;
  end

  env_update u_env_update (
    .x_i             (x_q[idx_q]),
    .env_i           (env_q[idx_q]),
    .attack_shift_i  (atk_q),
    .release_shift_i (rel_q),
    .env_o           (env_new)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idx_q     <= '0;
      atk_q     <= '0;
      rel_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N_FILTERS; i++) begin
        x_q[i]   <= '0;
        env_q[i] <= '0;
      end
    end else begin
      valid_q <= last;
      if (accept) begin
        x_q   <= filtered_channels;
        atk_q <= attack_shift;
        rel_q <= release_shift;
        idx_q <= '0;
      end
      if (running) begin
        env_q[idx_q] <= env_new;
        idx_q        <= idx_q + 1'b1;
        // A frame arriving mid-walk is dropped; the latched frame is untouched.
        if (valid_in) overrun_q <= 1'b1;
      end
    end
  end

  assign envelope_channels = env_q;
  assign valid_out         = valid_q;
  assign overrun_out       = overrun_q;

endmodule

// File: tb/tb_envelope_follower.sv
// Directed bench for envelope_follower with hand-computed expected envelopes.
module tb_envelope_follower;

  localparam int N = 8;

  logic              clk    = 1'b0;
  logic              rst    = 1'b1;
  logic              vin    = 1'b0;
  logic        [4:0] atk    = '0;
  logic        [4:0] rel    = '0;
  logic signed [31:0] fch [N];
  logic signed [31:0] ech [N];
  logic              vout, busy, ovr;

  int checks   = 0;
  int failures = 0;
  int cyc, bcnt, vcnt;

  always #5 clk = ~clk;

  envelope_follower #(
    .N_FILTERS (N)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .valid_in          (vin),
    .attack_shift      (atk),
    .release_shift     (rel),
    .filtered_channels (fch),
    .envelope_channels (ech),
    .valid_out         (vout),
    .busy_out          (busy),
    .overrun_out       (ovr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic signed [31:0] v);
    for (int i = 0; i < N; i++) fch[i] = v;
  endtask

  // From just after the accepting edge, step to the negedge where valid_out is high.
  task automatic wait_done(output int c, output int b);
    c = 0;
    b = 0;
    while (!vout && c < 20) begin
      if (busy) b++;
      @(negedge clk);
      c++;
    end
  endtask

  task automatic run_frame(input string tag);
    @(negedge clk);
    vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    wait_done(cyc, bcnt);
    check({tag, "_latency"}, cyc, 8);
  endtask

  initial begin
    set_all(0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_valid", {31'd0, vout}, 0);
    check("rst_ovr", {31'd0, ovr}, 0);
    check("rst_env0", ech[0], 0);
    check("rst_env7", ech[7], 0);

    // All 1000, shifts 0.
    set_all(1000);
    atk = 0;
    rel = 0;
    run_frame("f1000");
    check("f1000_busy_cycles", bcnt, 8);
    check("f1000_busy_at_valid", {31'd0, busy}, 0);
    for (int i = 0; i < N; i++) check($sformatf("f1000_env%0d", i), ech[i], 1000);
    @(negedge clk);
    check("valid_one_cycle", {31'd0, vout}, 0);

    // Negative input rectifies to the same envelope.
    set_all(-1000);
    run_frame("fneg");
    check("fneg_env0", ech[0], 1000);
    check("fneg_env7", ech[7], 1000);

    // Most negative sample saturates.
    fch[3] = 32'sh8000_0000;
    run_frame("fmin");
    check("fmin_env3", ech[3], 32'h7fff_ffff);
    check("fmin_env2", ech[2], 1000);

    // Attack 2 from zero: 0 -> 100 -> 175.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_all(400);
    atk = 2;
    run_frame("atk1");
    check("atk1_env0", ech[0], 100);
    check("atk1_env5", ech[5], 100);
    run_frame("atk2");
    check("atk2_env0", ech[0], 175);
    check("atk2_env7", ech[7], 175);

    // Release 1 from 400 towards 0 -> 200.
    atk = 0;
    run_frame("to400");
    check("to400_env4", ech[4], 400);
    set_all(0);
    rel = 1;
    run_frame("rel1");
    check("rel1_env0", ech[0], 200);
    check("rel1_env6", ech[6], 200);

    // Huge attack shift leaves the envelope unchanged.
    set_all(1000);
    atk = 31;
    run_frame("atk31");
    check("atk31_env1", ech[1], 200);

    // Overrun: second valid three cycles into the walk is dropped.
    atk = 0;
    rel = 0;
    set_all(500);
    @(negedge clk);
    vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    repeat (2) @(negedge clk);
    set_all(9999);
    vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    check("ovr_set", {31'd0, ovr}, 1);
    check("ovr_still_busy", {31'd0, busy}, 1);
    wait_done(cyc, bcnt);
    check("ovr_latency", cyc, 5);
    check("ovr_env0", ech[0], 500);
    check("ovr_env7", ech[7], 500);
    // Accept a frame coincident with valid_out.
    set_all(700);
    vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    check("coinc_busy", {31'd0, busy}, 1);
    check("coinc_valid_low", {31'd0, vout}, 0);
    check("ovr_sticky", {31'd0, ovr}, 1);
    wait_done(cyc, bcnt);
    check("coinc_latency", cyc, 8);
    check("coinc_env3", ech[3], 700);
    check("ovr_sticky2", {31'd0, ovr}, 1);

    // Reset during the walk aborts the frame.
    set_all(300);
    @(negedge clk);
    vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_env0", ech[0], 300);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_env0", ech[0], 0);
    check("abort_env7", ech[7], 0);
    check("abort_ovr", {31'd0, ovr}, 0);
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (vout) vcnt++;
      @(negedge clk);
    end
    check("abort_no_valid", vcnt, 0);

    // Reset wins over valid_in in IDLE.
    rst = 1'b1;
    vin = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vin = 1'b0;
    check("rst_prio_busy", {31'd0, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/envelope_follower.md
ENVELOPE_FOLLOWER -- requirements
Module: envelope_follower

Interface
REQ-001 The module SHALL have parameter N_FILTERS, default 8, giving the number of band channels (legal range 2..64).
REQ-002 The module SHALL have port clk_in, input, 1 bit: the single clock.
REQ-003 The module SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port valid_in, input, 1 bit: a new frame of filtered modulator samples is present.
REQ-005 The module SHALL have port attack_shift, input, 5 bits: the rise smoothing shift.
REQ-006 The module SHALL have port release_shift, input, 5 bits: the fall smoothing shift.
REQ-007 The module SHALL have port filtered_channels[N_FILTERS], input, signed 32 bits each: the band-pass modulator outputs.
REQ-008 The module SHALL have port envelope_channels[N_FILTERS], output, signed 32 bits each: per-band envelopes feeding the mixer.
REQ-009 The module SHALL have port valid_out, output, 1 bit: one-cycle pulse marking a complete, consistent envelope frame.
REQ-010 The module SHALL have port busy_out, output, 1 bit: high while a frame is being processed.
REQ-011 The module SHALL have port overrun_out, output, 1 bit: sticky flag set when a frame was dropped.

Function
REQ-012 The FSM SHALL have two states: IDLE and RUN.
REQ-013 In IDLE with valid_in=1, the module SHALL, on that edge, latch all filtered_channels, attack_shift and release_shift, set channel index idx=0, and enter RUN.
REQ-014 In RUN, each cycle SHALL update exactly one envelope register, env[idx], then increment idx; time-multiplexed, one shared update datapath.
REQ-015 The update SHALL be: r = |x[idx]| with -2^31 saturating to 2^31-1; if r > env, env += (r-env)>>>attack_shift, else env -= (env-r)>>>release_shift; all arithmetic 33-bit signed, result in [0, 2^31-1].
REQ-016 A shift of 0 SHALL make env equal r; a shift large enough that the difference shifts to 0 (e.g. 31) SHALL leave env unchanged.
REQ-017 When idx=N_FILTERS-1 is updated, the module SHALL return to IDLE and register valid_out=1 for exactly one cycle.
REQ-018 Latency: with valid_in sampled at edge 0, valid_out SHALL be high in the cycle after edge N_FILTERS.
REQ-019 busy_out SHALL equal (state==RUN).
REQ-020 envelope_channels SHALL drive env[] directly; values are guaranteed consistent only while valid_out=1 or in IDLE.
REQ-021 A valid_in arriving while in RUN SHALL be dropped without disturbing the frame in progress, and SHALL set overrun_out.
REQ-022 A valid_in in the same cycle valid_out is high SHALL be accepted, because the state is IDLE in that cycle.
REQ-023 overrun_out SHALL be cleared only by reset.

Reset
REQ-024 Reset SHALL force state=IDLE, idx=0, all env[]=0, valid_out=0, busy_out=0, overrun_out=0, and the latched inputs to 0.
REQ-025 Reset mid-RUN SHALL abort the frame with no valid_out pulse, and rst_in SHALL take priority over valid_in.

Structure
REQ-026 A shared package vocoder_pkg SHALL hold the sample-width constant (32), the default N_FILTERS, and the FSM state enum typedef.
REQ-027 One combinational sub-module, env_update, SHALL implement REQ-015/016 for a single channel (inputs: x, env, attack_shift, release_shift; output: new env).

Verification
REQ-028 N=8, shifts 0/0, all inputs 1000, valid_in once -> busy_out for 8 cycles, valid_out one cycle after edge 8, all envelopes 1000, then all inputs -1000 -> envelopes 1000.
REQ-029 Input -2147483648 on ch3, attack 0 -> envelope_channels[3]=2147483647.
REQ-030 attack 2, env 0, input 400, two frames -> 100 then 175; release 1, env 400, input 0 -> 200.
REQ-031 valid_in again 3 cycles into RUN -> frame completes unchanged, overrun_out=1 and stays 1; valid_in coincident with valid_out -> accepted, busy_out next cycle.
REQ-032 rst_in at cycle 4 of RUN -> next cycle all envelopes 0, busy_out=0, no valid_out pulse follows.
